seletor_produto: RTL and testbench

// Parametrised, clocked successor of the combinational product selector. Latches a
// (linha, coluna) keypad selection, looks up price from a parameter table, tracks per-slot

---
 rtl/seletor_produto_if.sv | 30 +++
 rtl/seletor_produto.sv | 144 ++++++++++++++
 tb/tb_seletor_produto.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seletor_produto_if.sv
// rtl/seletor_produto_if.sv - keypad/vend-side bundle for the product selector
interface seletor_produto_if #(
  parameter int ROW_W   = 2,
  parameter int COL_W   = 2,
  parameter int PRICE_W = 3
);
  logic                     enable;
  logic                     sel_valid;
  logic [ROW_W-1:0]         linha;
  logic [COL_W-1:0]         coluna;
  logic                     dispense_done;
  logic                     cancel;
  logic                     restock;
  logic                     sel_ready;
  logic [PRICE_W-1:0]       valor;
  logic [ROW_W+COL_W-1:0]   codeOut;
  logic                     existe;
  logic                     esgotado;
  logic                     rejeitado;

  modport master (
    output enable, sel_valid, linha, coluna, dispense_done, cancel, restock,
    input  sel_ready, valor, codeOut, existe, esgotado, rejeitado
  );

  modport slave (
    input  enable, sel_valid, linha, coluna, dispense_done, cancel, restock,
    output sel_ready, valor, codeOut, existe, esgotado, rejeitado
  );
endinterface

// File: rtl/seletor_produto.sv
// rtl/seletor_produto.sv - clocked product selector with price lookup, stock and hold timeout
module seletor_produto #(
  parameter int ROW_W       = 2,
  parameter int COL_W       = 2,
  parameter int PRICE_W     = 3,
  parameter int STOCK_W     = 4,
  parameter int STOCK_INIT  = 5,
  parameter int TIMEOUT_CYC = 1000,
  parameter logic [(2**(ROW_W+COL_W))*PRICE_W-1:0] PRICE_TABLE = {
    3'd0, 3'd0, 3'd5, 3'd2, 3'd4, 3'd5, 3'd3, 3'd1,
    3'd0, 3'd0, 3'd1, 3'd6, 3'd0, 3'd0, 3'd0, 3'd2}
) (
  input logic               clk,
  input logic               rst,
  seletor_produto_if.slave  bus
);
  localparam int CODE_W = ROW_W + COL_W;
  localparam int N_SLOT = 2**CODE_W;
  localparam int CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [CODE_W-1:0]  code_out_q, code_out_d;
  logic [PRICE_W-1:0] valor_q, valor_d;
  logic               existe_q, existe_d;
  logic               esgotado_q, esgotado_d;
  logic               rejeitado_q, rejeitado_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STOCK_W-1:0] stock_q [N_SLOT];
  logic [STOCK_W-1:0] stock_d [N_SLOT];

  logic [PRICE_W-1:0] price;
  logic [STOCK_W-1:0] stk;

  assign price = PRICE_TABLE[int'(code_q)*PRICE_W +: PRICE_W];
  assign stk   = stock_q[code_q];

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    code_out_d  = code_out_q;
    valor_d     = valor_q;
    existe_d    = existe_q;
    esgotado_d  = esgotado_q;
    rejeitado_d = 1'b0;
    cnt_d       = cnt_q;
    stock_d     = stock_q;

    if (!bus.enable) begin
      state_d    = S_IDLE;
      code_out_d = '1;
      valor_d    = '0;
      existe_d   = 1'b0;
      esgotado_d = 1'b0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.sel_valid) begin
            code_d  = {bus.linha, bus.coluna};
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          existe_d = 1'b0;
          valor_d  = '0;
          if (price != '0 && stk != '0) begin
            valor_d    = price;
            code_out_d = code_q;
            existe_d   = 1'b1;
            esgotado_d = 1'b0;
            cnt_d      = '0;
            state_d    = S_HOLD;
          end else if (price != '0) begin
            code_out_d  = code_q;
            esgotado_d  = 1'b1;
            rejeitado_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            code_out_d  = '1;
            esgotado_d  = 1'b0;
            rejeitado_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
        S_HOLD: begin
          // dispense_done outranks cancel, which outranks the timeout
          if (bus.dispense_done || bus.cancel || cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            if (bus.dispense_done && stock_q[code_out_q] != '0)
              stock_d[code_out_q] = stock_q[code_out_q] - 1'b1;
            state_d    = S_IDLE;
            code_out_d = '1;
            valor_d    = '0;
            existe_d   = 1'b0;
            esgotado_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Restock is applied last so it overrides a same-cycle decrement
    if (bus.restock) begin
      for (int i = 0; i < N_SLOT; i++) stock_d[i] = STOCK_W'(STOCK_INIT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      code_q      <= '0;
      code_out_q  <= '1;
      valor_q     <= '0;
      existe_q    <= 1'b0;
      esgotado_q  <= 1'b0;
      rejeitado_q <= 1'b0;
      cnt_q       <= '0;
      for (int i = 0; i < N_SLOT; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      code_out_q  <= code_out_d;
      valor_q     <= valor_d;
      existe_q    <= existe_d;
      esgotado_q  <= esgotado_d;
      rejeitado_q <= rejeitado_d;
      cnt_q       <= cnt_d;
      stock_q     <= stock_d;
    end
  end

  assign bus.sel_ready = (state_q == S_IDLE) && bus.enable;
  assign bus.valor     = valor_q;
  assign bus.codeOut   = code_out_q;
  assign bus.existe    = existe_q;
  assign bus.esgotado  = esgotado_q;
  assign bus.rejeitado = rejeitado_q;
endmodule

// File: tb/tb_seletor_produto.sv
// tb/tb_seletor_produto.sv - randomized scenario bench for seletor_produto against a slot/stock model
module tb_seletor_produto;
  localparam int TO = 16;

  typedef struct packed {
    logic       sel_ready;
    logic       existe;
    logic       esgotado;
    logic       rejeitado;
    logic [2:0] valor;
    logic [3:0] code;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  int   stk [16];
  logic held = 1'b0;
  logic [3:0] held_code = '0;

  seletor_produto_if #(.ROW_W(2), .COL_W(2), .PRICE_W(3)) bus ();

  seletor_produto #(.TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int price_of(input logic [3:0] c);
    case (c)
      4'b0000: return 2;
      4'b0100: return 6;
      4'b0101: return 1;
      4'b1000: return 1;
      4'b1001: return 3;
      4'b1010: return 5;
      4'b1011: return 4;
      4'b1100: return 2;
      4'b1101: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic out_t exp_idle(input logic en);
    return '{sel_ready: en, existe: 1'b0, esgotado: 1'b0, rejeitado: 1'b0, valor: 3'd0, code: 4'hF};
  endfunction

  function automatic out_t mdl_select(input logic [3:0] c);
    int p;
    p = price_of(c);
    if (p == 0) begin
      held = 1'b0;
      return '{sel_ready: 1'b1, existe: 1'b0, esgotado: 1'b0, rejeitado: 1'b1, valor: 3'd0, code: 4'hF};
    end else if (stk[c] == 0) begin
      held = 1'b0;
      return '{sel_ready: 1'b1, existe: 1'b0, esgotado: 1'b1, rejeitado: 1'b1, valor: 3'd0, code: c};
    end
    held = 1'b1;
    held_code = c;
    return '{sel_ready: 1'b0, existe: 1'b1, esgotado: 1'b0, rejeitado: 1'b0, valor: 3'(p), code: c};
  endfunction

  function automatic void mdl_restock();
    for (int i = 0; i < 16; i++) stk[i] = 5;
  endfunction

  function automatic void mdl_dispense();
    if (held && stk[held_code] > 0) stk[held_code] = stk[held_code] - 1;
    held = 1'b0;
  endfunction

  function automatic out_t sample();
    return '{sel_ready: bus.sel_ready, existe: bus.existe, esgotado: bus.esgotado,
             rejeitado: bus.rejeitado, valor: bus.valor, code: bus.codeOut};
  endfunction

  function automatic logic [3:0] rand_valid_code();
    logic [3:0] c;
    do c = 4'($urandom_range(0, 15)); while (price_of(c) == 0);
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_select(input logic [3:0] c, output out_t obs);
    bus.sel_valid = 1'b1;
    bus.linha     = c[3:2];
    bus.coluna    = c[1:0];
    tick();
    bus.sel_valid = 1'b0;
    tick();
    obs = sample();
  endtask

  task automatic pulse(input logic d, input logic cn, input logic rs);
    bus.dispense_done = d;
    bus.cancel        = cn;
    bus.restock       = rs;
    tick();
    bus.dispense_done = 1'b0;
    bus.cancel        = 1'b0;
    bus.restock       = 1'b0;
  endtask

  task automatic test_reset();
    out_t obs;
    rst = 1'b1;
    bus.enable = 1'b1;
    bus.sel_valid = 1'b1;
    bus.dispense_done = 1'b1;
    tick();
    tick();
    bus.sel_valid = 1'b0;
    bus.dispense_done = 1'b0;
    rst = 1'b0;
    mdl_restock();
    held = 1'b0;
    obs = sample();
    n_cmp++;
    if (obs !== exp_idle(1'b1)) begin
      n_err++;
      $display("FAIL reset obs=%h exp=%h", obs, exp_idle(1'b1));
    end
  endtask

  task automatic test_basic();
    out_t obs, ex;
    do_select(4'b0101, obs);
    ex = mdl_select(4'b0101);
    n_cmp++;
    if (obs !== ex) begin n_err++; $display("FAIL basic_sel obs=%h exp=%h", obs, ex); end
    pulse(1'b1, 1'b0, 1'b0);
    mdl_dispense();
    obs = sample();
    n_cmp++;
    if (obs !== exp_idle(1'b1)) begin n_err++; $display("FAIL basic_disp obs=%h exp=%h", obs, exp_idle(1'b1)); end
  endtask

  task automatic test_invalid();
    out_t obs, ex;
    do_select(4'b0011, obs);
    ex = mdl_select(4'b0011);
    n_cmp++;
    if (obs !== ex) begin n_err++; $display("FAIL invalid_sel obs=%h exp=%h", obs, ex); end
    tick();
    ex.rejeitado = 1'b0;
    obs = sample();
    n_cmp++;
    if (obs !== ex) begin n_err++; $display("FAIL invalid_hold obs=%h exp=%h", obs, ex); end
  endtask

  task automatic test_soldout();
    out_t obs, ex;
    pulse(1'b0, 1'b0, 1'b1);
    mdl_restock();
    for (int i = 0; i < 6; i++) begin
      do_select(4'b0000, obs);
      ex = mdl_select(4'b0000);
      n_cmp++;
      if (obs !== ex) begin n_err++; $display("FAIL soldout_sel%0d obs=%h exp=%h", i, obs, ex); end
      if (held) begin pulse(1'b1, 1'b0, 1'b0); mdl_dispense(); end
    end
    tick();
    ex.rejeitado = 1'b0;
    obs = sample();
    n_cmp++;
    if (obs !== ex) begin n_err++; $display("FAIL soldout_hold obs=%h exp=%h", obs, ex); end
    pulse(1'b0, 1'b0, 1'b1);
    mdl_restock();
    do_select(4'b0000, obs);
    ex = mdl_select(4'b0000);
    n_cmp++;
    if (obs !== ex) begin n_err++; $display("FAIL soldout_restock obs=%h exp=%h", obs, ex); end
    pulse(1'b0, 1'b1, 1'b0);
    held = 1'b0;
  endtask

  task automatic test_timeout();
    out_t obs, ex;
    do_select(4'b1001, obs);
    ex = mdl_select(4'b1001);
    n_cmp++;
    if (obs !== ex) begin n_err++; $display("FAIL timeout_sel obs=%h exp=%h", obs, ex); end
    for (int i = 0; i < TO - 1; i++) tick();
    obs = sample();
    n_cmp++;
    if (obs !== ex) begin n_err++; $display("FAIL timeout_early obs=%h exp=%h", obs, ex); end
    tick();
    held = 1'b0;
    obs = sample();
    n_cmp++;
    if (obs !== exp_idle(1'b1)) begin n_err++; $display("FAIL timeout_release obs=%h exp=%h", obs, exp_idle(1'b1)); end
    for (int i = 0; i < 6; i++) begin
      do_select(4'b1001, obs);
      ex = mdl_select(4'b1001);
      n_cmp++;
      if (obs !== ex) begin n_err++; $display("FAIL timeout_stock%0d obs=%h exp=%h", i, obs, ex); end
      if (held) begin pulse(1'b1, 1'b0, 1'b0); mdl_dispense(); end
    end
  endtask

  task automatic test_priority();
    out_t obs, ex;
    logic [3:0] s;
    s = rand_valid_code();
    pulse(1'b0, 1'b0, 1'b1);
    mdl_restock();
    do_select(s, obs);
    ex = mdl_select(s);
    pulse(1'b1, 1'b1, 1'b0);
    mdl_dispense();
    obs = sample();
    n_cmp++;
    if (obs !== exp_idle(1'b1)) begin n_err++; $display("FAIL prio_release obs=%h exp=%h", obs, exp_idle(1'b1)); end
    for (int i = 0; i < 5; i++) begin
      do_select(s, obs);
      ex = mdl_select(s);
      n_cmp++;
      if (obs !== ex) begin n_err++; $display("FAIL prio_drain%0d obs=%h exp=%h", i, obs, ex); end
      if (held) begin pulse(1'b1, 1'b0, 1'b0); mdl_dispense(); end
    end
    pulse(1'b0, 1'b0, 1'b1);
    mdl_restock();
    do_select(s, obs);
    ex = mdl_select(s);
    pulse(1'b1, 1'b0, 1'b1);
    held = 1'b0;
    mdl_restock();
    obs = sample();
    n_cmp++;
    if (obs !== exp_idle(1'b1)) begin n_err++; $display("FAIL prio_restock_rel obs=%h exp=%h", obs, exp_idle(1'b1)); end
    for (int i = 0; i < 6; i++) begin
      do_select(s, obs);
      ex = mdl_select(s);
      n_cmp++;
      if (obs !== ex) begin n_err++; $display("FAIL prio_refill%0d obs=%h exp=%h", i, obs, ex); end
      if (held) begin pulse(1'b1, 1'b0, 1'b0); mdl_dispense(); end
    end
  endtask

  task automatic test_enable();
    out_t obs, ex;
    logic [3:0] s;
    pulse(1'b0, 1'b0, 1'b1);
    mdl_restock();
    s = rand_valid_code();
    do_select(s, obs);
    ex = mdl_select(s);
    bus.enable = 1'b0;
    tick();
    held = 1'b0;
    obs = sample();
    n_cmp++;
    if (obs !== exp_idle(1'b0)) begin n_err++; $display("FAIL enable_low obs=%h exp=%h", obs, exp_idle(1'b0)); end
    bus.enable = 1'b1;
    #1;
    obs = sample();
    n_cmp++;
    if (obs !== exp_idle(1'b1)) begin n_err++; $display("FAIL enable_high obs=%h exp=%h", obs, exp_idle(1'b1)); end
    // Keep strobing other codes through CHECK and HOLD; the held code must not change
    bus.sel_valid = 1'b1;
    bus.linha = s[3:2];
    bus.coluna = s[1:0];
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.linha = 2'($urandom_range(0, 3));
      bus.coluna = 2'($urandom_range(0, 3));
      tick();
    end
    bus.sel_valid = 1'b0;
    ex = mdl_select(s);
    obs = sample();
    n_cmp++;
    if (obs !== ex) begin n_err++; $display("FAIL ignore_sel obs=%h exp=%h", obs, ex); end
    pulse(1'b0, 1'b1, 1'b0);
    held = 1'b0;
    obs = sample();
    n_cmp++;
    if (obs !== exp_idle(1'b1)) begin n_err++; $display("FAIL ignore_cancel obs=%h exp=%h", obs, exp_idle(1'b1)); end
  endtask

  task automatic test_random();
    out_t obs, ex;
    logic [3:0] c;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        pulse(1'b0, 1'b0, 1'b1);
        mdl_restock();
      end
      c = 4'($urandom_range(0, 15));
      do_select(c, obs);
      ex = mdl_select(c);
      n_cmp++;
      if (obs !== ex) begin n_err++; $display("FAIL rand_sel%0d code=%h obs=%h exp=%h", i, c, obs, ex); end
      if (held) begin
        if ($urandom_range(0, 2) != 0) begin
          pulse(1'b1, 1'b0, 1'b0);
          mdl_dispense();
        end else begin
          pulse(1'b0, 1'b1, 1'b0);
          held = 1'b0;
        end
        obs = sample();
        n_cmp++;
        if (obs !== exp_idle(1'b1)) begin n_err++; $display("FAIL rand_rel%0d obs=%h exp=%h", i, obs, exp_idle(1'b1)); end
      end
    end
  endtask

  initial begin
    bus.enable = 1'b1;
    bus.sel_valid = 1'b0;
    bus.linha = '0;
    bus.coluna = '0;
    bus.dispense_done = 1'b0;
    bus.cancel = 1'b0;
    bus.restock = 1'b0;
    test_reset();
    test_basic();
    test_invalid();
    test_soldout();
    test_timeout();
    test_priority();
    test_enable();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
